// File: rtl/rsp_xarb_pkg.sv
// Shared types and sizes for the response crossbar scheduler.
// Per-target lock state and index helpers.
package rsp_xarb_pkg;

  localparam int NI   = 5;
  localparam int NT   = 3;
  localparam int IDXW = $clog2(NI);

  typedef logic [IDXW-1:0] idx_t;

  typedef struct packed {
    logic lock_vld;
    idx_t owner;
    idx_t ptr;
  } tgt_state_t;

  // Source index plus one, wrapping at NI.
  function automatic idx_t inc_mod(idx_t v);
    return (v == idx_t'(NI - 1)) ? '0 : v + idx_t'(1);
  endfunction

endpackage

// File: rtl/rsp_xarb_if.sv
// Source/target handshake and matrix request bundle.
// slave: scheduler side, master: sources/targets side.
interface rsp_xarb_if;
  import rsp_xarb_pkg::*;

  logic [NI-1:0]    src_vld;
  logic [NI*NT-1:0] src_dst;
  logic [NI-1:0]    src_last;
  logic [NI-1:0]    src_rdy;
  logic [NT-1:0]    tgt_vld;
  logic [NT-1:0]    tgt_rdy;
  logic [NI*NT-1:0] xreq;
  logic             err;

  modport slave (
    input  src_vld, src_dst, src_last, tgt_rdy,
    output src_rdy, tgt_vld, xreq, err
  );

  modport master (
    output src_vld, src_dst, src_last, tgt_rdy,
    input  src_rdy, tgt_vld, xreq, err
  );

endinterface

// File: rtl/rsp_rr_pick.sv
// Combinational round-robin picker over NI requesters.
// Scans ptr, ptr+1, ... and grants the first set request.
module rsp_rr_pick
  import rsp_xarb_pkg::*;
(
  input  logic [NI-1:0] req_i,
  input  idx_t          ptr_i,
  output logic          gnt_vld_o,
  output idx_t          gnt_idx_o
);

  int j;

  // First requester at or after ptr, wrapping.
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    j         = 0;
    for (int k = 0; k < NI; k++) begin
      j = (int'(ptr_i) + k) % NI;
      if (!gnt_vld_o && req_i[j]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = idx_t'(j);
      end
    end
  end

endmodule

// File: rtl/rsp_xarb.sv
// Packet-level scheduler for the response crossbar.
// Per-target round-robin lock held until the last beat.
module rsp_xarb
  import rsp_xarb_pkg::*;
(
  input logic clk,
  input logic rst,
  rsp_xarb_if.slave bus
);

  localparam logic [NI-1:0] ONE = NI'(1);

  tgt_state_t st_q [NT];
  tgt_state_t st_d [NT];
  logic       err_q, err_d;

  logic [NI-1:0]    oh;
  logic [NI-1:0]    owns;
  logic [NI-1:0]    bad;
  logic [NI-1:0]    elig  [NT];
  logic [NI-1:0]    req_m [NT];
  logic [NI-1:0]    mask  [NT+1];
  logic [NT-1:0]    gv;
  idx_t             gi    [NT];
  logic [NT-1:0]    done;
  logic [NI*NT-1:0] xreq_w;
  logic [NT-1:0]    tvld_w;
  logic [NI-1:0]    srdy_w;
  logic [NT-1:0]    dst;

  // Matrix requests and handshakes from the registered locks.
  always_comb begin
    xreq_w = '0;
    tvld_w = '0;
    srdy_w = '0;
    done   = '0;
    for (int t = 0; t < NT; t++) begin
      for (int i = 0; i < NI; i++) begin
        xreq_w[i*NT+t] = st_q[t].lock_vld &&
                         (st_q[t].owner == idx_t'(i));
      end
      tvld_w[t] = st_q[t].lock_vld &&
                  bus.src_vld[st_q[t].owner];
      done[t]   = tvld_w[t] && bus.tgt_rdy[t] &&
                  bus.src_last[st_q[t].owner];
    end
    for (int i = 0; i < NI; i++) begin
      srdy_w[i] = |(xreq_w[i*NT +: NT] & bus.tgt_rdy);
    end
  end

  // Eligibility: valid, exactly one-hot target, no lock held.
  always_comb begin
    oh   = '0;
    owns = '0;
    bad  = '0;
    dst  = '0;
    for (int t = 0; t < NT; t++) begin
      elig[t] = '0;
    end
    for (int i = 0; i < NI; i++) begin
      dst     = bus.src_dst[i*NT +: NT];
      oh[i]   = $onehot(dst);
      bad[i]  = bus.src_vld[i] && !oh[i];
      owns[i] = |xreq_w[i*NT +: NT];
      for (int t = 0; t < NT; t++) begin
        elig[t][i] = bus.src_vld[i] && oh[i] &&
                     dst[t] && !owns[i];
      end
    end
  end

  assign mask[0] = '0;

  for (genvar t = 0; t < NT; t++) begin : g_pick
    assign req_m[t] = elig[t] & ~mask[t];

    rsp_rr_pick u_pick (
      .req_i     (req_m[t]),
      .ptr_i     (st_q[t].ptr),
      .gnt_vld_o (gv[t]),
      .gnt_idx_o (gi[t])
    );

    // A source taken by a lower target is hidden from higher ones.
    assign mask[t+1] = mask[t] |
      ((!st_q[t].lock_vld && gv[t]) ? (ONE << gi[t]) : '0);
  end

  // Per-target IDLE/BUSY transitions and sticky error.
  always_comb begin
    st_d  = st_q;
    err_d = err_q || (|bad);
    for (int t = 0; t < NT; t++) begin
      if (!st_q[t].lock_vld) begin
        if (gv[t]) begin
          st_d[t].lock_vld = 1'b1;
          st_d[t].owner    = gi[t];
        end
      end else if (done[t]) begin
        st_d[t].lock_vld = 1'b0;
        st_d[t].ptr      = inc_mod(st_q[t].owner);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < NT; t++) begin
        st_q[t] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      err_q <= err_d;
    end
  end

  assign bus.xreq    = xreq_w;
  assign bus.tgt_vld = tvld_w;
  assign bus.src_rdy = srdy_w;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_rsp_xarb.sv
// Randomized scoreboard bench for rsp_xarb.
// Cycle-level reference model; monitor compares at negedge.
module tb_rsp_xarb;
  import rsp_xarb_pkg::*;

  localparam int NCYC = 1600;

  typedef struct {
    logic [NI*NT-1:0] xreq;
    logic [NT-1:0]    tv;
    logic [NI-1:0]    rdy;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  rsp_xarb_if bus ();

  rsp_xarb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model state
  bit m_lock [NT];
  int m_own  [NT];
  int m_ptr  [NT];
  bit m_err;

  // stimulus state
  int bl [NI];
  int pd [NI];
  logic [NI-1:0] cur_rdy;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int dst_of(int i);
    logic [NT-1:0] v;
    v = bus.src_dst[i*NT +: NT];
    if ($countones(v) != 1) return -1;
    for (int t = 0; t < NT; t++) if (v[t]) return t;
    return -1;
  endfunction

  function automatic bit m_owns(int i);
    for (int t = 0; t < NT; t++)
      if (m_lock[t] && m_own[t] == i) return 1;
    return 0;
  endfunction

  task automatic m_reset();
    for (int t = 0; t < NT; t++) begin
      m_lock[t] = 0; m_own[t] = 0; m_ptr[t] = 0;
    end
    m_err = 0;
  endtask

  // Apply one clock edge to the model using current inputs.
  task automatic m_edge();
    bit nl [NT];
    int no [NT];
    int np [NT];
    bit taken [NI];
    for (int i = 0; i < NI; i++) taken[i] = 0;
    for (int t = 0; t < NT; t++) begin
      nl[t] = m_lock[t]; no[t] = m_own[t]; np[t] = m_ptr[t];
      if (m_lock[t]) begin
        int o;
        o = m_own[t];
        if (bus.src_vld[o] && bus.tgt_rdy[t] && bus.src_last[o]) begin
          nl[t] = 0;
          np[t] = (o + 1) % NI;
        end
      end else begin
        for (int k = 0; k < NI; k++) begin
          int i;
          i = (m_ptr[t] + k) % NI;
          if (!nl[t] && bus.src_vld[i] && dst_of(i) == t &&
              !m_owns(i) && !taken[i]) begin
            nl[t] = 1; no[t] = i; taken[i] = 1;
          end
        end
      end
    end
    for (int i = 0; i < NI; i++)
      if (bus.src_vld[i] && dst_of(i) < 0) m_err = 1;
    for (int t = 0; t < NT; t++) begin
      m_lock[t] = nl[t]; m_own[t] = no[t]; m_ptr[t] = np[t];
    end
  endtask

  function automatic exp_t m_out();
    exp_t e;
    e.xreq = '0; e.tv = '0; e.rdy = '0; e.err = m_err;
    for (int t = 0; t < NT; t++) begin
      if (m_lock[t]) begin
        e.xreq[m_own[t]*NT + t] = 1'b1;
        e.tv[t] = bus.src_vld[m_own[t]];
        if (bus.tgt_rdy[t]) e.rdy[m_own[t]] = 1'b1;
      end
    end
    return e;
  endfunction

  // New random source/target stimulus for one cycle.
  task automatic drive(int cyc);
    bit fair, ill;
    fair = (cyc >= 800 && cyc < 1100);
    ill  = (cyc >= 400 && cyc < 600);
    for (int i = 0; i < NI; i++) begin
      if (bl[i] == 0 && $urandom_range(0, 2) != 0) begin
        pd[i] = fair ? 0 : $urandom_range(0, NT - 1);
        bl[i] = fair ? 1 : $urandom_range(1, 4);
      end
      if (bl[i] > 0) begin
        bus.src_vld[i]  = fair || ($urandom_range(0, 4) != 0);
        bus.src_dst[i*NT +: NT] = NT'(1) << pd[i];
        bus.src_last[i] = (bl[i] == 1);
      end else if (ill && $urandom_range(0, 3) == 0) begin
        bus.src_vld[i]  = 1'b1;
        bus.src_dst[i*NT +: NT] = NT'(3);
        bus.src_last[i] = 1'b1;
      end else begin
        bus.src_vld[i]  = 1'b0;
        bus.src_dst[i*NT +: NT] = '0;
        bus.src_last[i] = 1'b0;
      end
    end
    for (int t = 0; t < NT; t++) begin
      if (fair && t == 0) bus.tgt_rdy[t] = 1'b1;
      else bus.tgt_rdy[t] = ($urandom_range(0, 2) != 0);
    end
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    bus.src_vld = '0; bus.src_dst = '0;
    bus.src_last = '0; bus.tgt_rdy = '0;
    for (int i = 0; i < NI; i++) begin bl[i] = 0; pd[i] = 0; end
    cur_rdy = '0;
    m_reset();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      // beats accepted at this edge
      if (!rst) begin
        for (int i = 0; i < NI; i++)
          if (bus.src_vld[i] && cur_rdy[i] && bl[i] > 0) bl[i]--;
        m_edge();
      end else begin
        m_reset();
      end
      rst = (cyc < 3) || (cyc == 300) || (cyc == 700) ||
            (cyc == 701) || (cyc == 1200);
      if (rst) m_reset();
      drive(cyc);
      e = m_out();
      cur_rdy = e.rdy;
      q.push_back(e);
    end
    repeat (2) @(posedge clk);
    chk("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Monitor: pop expected and compare DUT outputs.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [NT-1:0] acc;
      e = q.pop_front();
      chk("xreq", 32'(bus.xreq), 32'(e.xreq));
      chk("tgt_vld", 32'(bus.tgt_vld), 32'(e.tv));
      chk("src_rdy", 32'(bus.src_rdy), 32'(e.rdy));
      chk("err", 32'(bus.err), 32'(e.err));
      acc = '0;
      for (int i = 0; i < NI; i++) begin
        logic [NT-1:0] s;
        s = bus.xreq[i*NT +: NT];
        chk("onehot0", 32'($countones(s) <= 1), 32'(1));
        chk("disjoint", 32'(acc & s), 32'(0));
        acc = acc | s;
      end
    end
  end

endmodule

// File: doc/rsp_xarb.md
Name: rsp_xarb

Overview:
- Packet-level scheduler for the response crossbar matrix (rsp_XMatrix).
- Each response source Ii requests one target Tt.
- Per target, a round-robin arbiter picks one source and locks the path until the packet's last beat.
- Drives the matrix I*_req vectors, which are guaranteed onehot0 per source and never duplicated across sources, and generates the valid/ready handshake across the switch.

Parameters:
- NI, 5, number of response sources (matrix inputs I0..I{NI-1}).
- NT, 3, number of response targets (matrix outputs T0..T{NT-1}).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- src_vld  input  NI  source i has a beat pending.
- src_dst  input  NI*NT  one-hot target select of source i, slice [i*NT +: NT].
- src_last  input  NI  beat of source i is the packet's last.
- src_rdy  output  NI  beat of source i accepted this cycle.
- tgt_vld  output  NT  valid toward target t.
- tgt_rdy  input  NT  target t accepts a beat.
- xreq  output  NI*NT  matrix request vector of source i, slice [i*NT +: NT], wired to Ii_req.
- err  output  1  sticky protocol error.

Behaviour:
- State per target t:
  - lock_vld[t], 1 bit.
  - owner[t], clog2(NI) bits.
  - ptr[t], clog2(NI) bits (round-robin start).
- Reset (async): all lock_vld=0, owner=0, ptr=0, err=0. Therefore xreq=0, tgt_vld=0, src_rdy=0 during and after reset.
- Eligible request of source i for target t, all of the following:
  - src_vld[i]=1;
  - src_dst slice i is exactly one-hot with bit t set;
  - source i owns no lock on any target.
- A non-one-hot src_dst with src_vld=1 is ignored and sets err; err stays set until reset.
- Target FSM, two states:
  - IDLE (lock_vld=0): when any eligible request exists, pick the first eligible i scanning ptr, ptr+1, ... mod NI. At the clock edge set lock_vld=1 and owner=i, then go to BUSY. No eligible request: stay IDLE.
  - BUSY (lock_vld=1): go back to IDLE on the edge where src_vld[owner] & tgt_rdy[t] & src_last[owner]. On that edge clear lock_vld and set ptr=(owner+1) mod NI.
- Conflict between targets: if one source is the pick of two IDLE targets in the same cycle, the lowest target index wins. The other target recomputes its pick excluding that source in the same cycle. Result: at most one lock per source.
- Combinational outputs from registered state:
  - xreq[i*NT+t] = lock_vld[t] & (owner[t]==i).
  - tgt_vld[t] = lock_vld[t] & src_vld[owner[t]].
  - src_rdy[i] = OR over t of (xreq[i*NT+t] & tgt_rdy[t]).
- Latency: a request visible in cycle N gives a grant (xreq, tgt_vld) in cycle N+1. A beat transfers in any cycle with vld & rdy.
- Inter-packet bubble: after the last beat at edge E the target is IDLE during cycle E; the next grant appears at E+1. Minimum one idle cycle between packets on a target.
- Source drops src_vld mid-packet: the lock is held and tgt_vld=0 until the source resumes.
- Single-beat packet (src_last=1 on the first beat): lock lasts exactly one BUSY cycle if tgt_rdy=1.
- tgt_rdy=0: the lock is held indefinitely; other sources requesting that target wait.
- Source protocol rules:
  - src_dst and src_last stay stable while src_vld=1 and src_rdy=0.
  - src_dst stays constant for the whole packet.
- Required invariants:
  - every xreq slice is onehot0;
  - xreq slices are pairwise disjoint;
  - a source's xreq bit equals the bit of src_dst it requested.
- Matrix datapath for source i is valid exactly when its xreq slice is nonzero.

Decomposition:
- Package rsp_xarb_pkg:
  - NI, NT defaults;
  - IDXW = clog2(NI);
  - typedef idx_t logic[IDXW-1:0];
  - typedef tgt_state_t struct {lock_vld, owner, ptr}.
- Sub-module rsp_rr_pick:
  - pure combinational NI-wide round-robin picker;
  - inputs req[NI], ptr; outputs gnt_vld, gnt_idx;
  - instantiated NT times in target order, with the earlier grants masked out of later requests.

Test Plan:
- Reset mid-packet: with src0 locked to T2, assert rst for 1 cycle → xreq=0, tgt_vld=0, src_rdy=0 immediately. After release, src0 re-arbitrates and is granted T2 one cycle later.
- Round-robin fairness: src1, src2, src3 all request T0 continuously with 1-beat packets and tgt_rdy[0]=1 → grant order 1,2,3,1… with one idle cycle between grants. xreq slice values are 3'b001 only.
- Lock hold: src3 sends a 4-beat packet to T1 with tgt_rdy[1] toggled 1,0,1,0…; src4 also requests T1 → src4 not granted until src3's last beat is accepted. src4 then gets xreq4=3'b010 one cycle after.
- Parallel targets: src0→T2, src1→T0, src3→T1 in the same cycle → all three are granted next cycle with xreq0=100, xreq1=001, xreq3=010, and full throughput on all three.
- Illegal dst: src2 raises src_vld with src_dst=3'b011 → never granted, err=1 next cycle and stays 1, other sources unaffected.
- Single-source conflict: src3 holds a lock on T0 and issues a new request to T2 → not granted T2 until its T0 packet ends. Assertions check onehot0/disjoint xreq every cycle.
